// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a bank of common-anode 7-segment
// displays. A packed multi-digit value is captured into a shadow register on
// load_i and copied to the display register only when the digit index wraps,
// so a frame never shows a mix of old and new digits. One digit is scanned per
// slot of SCAN_DIV clocks; the first clock of every slot keeps all anodes off
// to avoid ghosting.
//
// Parameters:
//   NUM_DIGITS  digits scanned (1..8)
//   DIGIT_BITS  bits per digit (3 = octal, 4 = hex)
//   SCAN_DIV    clocks per digit slot (>= 2)
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    synchronous active-high reset
//   value_i  packed digits, digit 0 in the LSBs (rightmost display)
//   load_i   capture value_i into the shadow register
//   blank_i  hold all anodes off; scanning continues
//   seg_o    active-low segments {g,f,e,d,c,b,a}
//   an_o     active-low digit enables, at most one low
//   frame_o  one-cycle pulse at the start of each frame after a wrap
//
// Build option:
//   SEG7_LZS_EN  leading-zero suppression: zero digits above the most
//                significant nonzero digit keep their anode off.
//
// All outputs are registered from the current state, so they show the slot
// one cycle after the state registers enter it.

module seg7_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_BITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] value_i,
    input  logic                             load_i,
    input  logic                             blank_i,
    output logic [6:0]                       seg_o,
    output logic [NUM_DIGITS-1:0]            an_o,
    output logic                             frame_o
);

    localparam int VW = NUM_DIGITS * DIGIT_BITS;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         shd_q, shd_d;
    logic [VW-1:0]         dsp_q, dsp_d;
    logic                  pending_q, pending_d;
    logic                  wrap_q, wrap_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  cnt_end, idx_end, wrap;
    logic [3:0]            cur_digit;
    logic [NUM_DIGITS-1:0] lit;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Which digits may light their anode. Derived from dsp only, so it moves
    // only at commit.
`ifdef SEG7_LZS_EN
    logic seen_nz;
    always_comb begin
        lit     = '0;
        seen_nz = 1'b0;
        // Walk from the top digit down; a digit is shown once any digit at or
        // above it is nonzero. Digit 0 is always shown.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (dsp_q[k*DIGIT_BITS +: DIGIT_BITS] != '0) seen_nz = 1'b1;
            lit[k] = seen_nz;
        end
        lit[0] = 1'b1;
    end
`else
    always_comb begin
        lit = '1;
    end
`endif

    always_comb begin
        cnt_end = (cnt_q == CW'(SCAN_DIV - 1));
        idx_end = (idx_q == IW'(NUM_DIGITS - 1));
        wrap    = cnt_end && idx_end;

        cnt_d = cnt_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_end) idx_d = idx_end ? '0 : idx_q + 1'b1;

        // The commit uses the pre-edge shadow value; a load on the wrap edge
        // stays pending for the next wrap.
        shd_d     = load_i ? value_i : shd_q;
        dsp_d     = (wrap && pending_q) ? shd_q : dsp_q;
        pending_d = pending_q;
        if (wrap)   pending_d = 1'b0;
        if (load_i) pending_d = 1'b1;
        wrap_d    = wrap;

        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) cur_digit = 4'(dsp_q[k*DIGIT_BITS +: DIGIT_BITS]);
        end
        seg_d = glyph(cur_digit);

        // cnt=0 is the anti-ghost gap: every anode off.
        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k) && cnt_q != '0 && !blank_i && lit[k]) an_d[k] = 1'b0;
        end

        // wrap_q marks the first cycle of a new frame in the state registers;
        // registering it again lines it up with seg/an.
        frame_d = wrap_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shd_q     <= '0;
            dsp_q     <= '0;
            pending_q <= 1'b0;
            wrap_q    <= 1'b0;
            seg_q     <= 7'b1111111;
            an_q      <= '1;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shd_q     <= shd_d;
            dsp_q     <= dsp_d;
            pending_q <= pending_d;
            wrap_q    <= wrap_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            frame_q   <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a 4-digit hex instance (SCAN_DIV=4) tracked every cycle
// by a reference model feeding an expected queue, plus a 2-digit octal
// instance checked against fixed glyph values.

module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value0 = '0;
    logic        load0 = 1'b0;
    logic        blank0 = 1'b0;
    logic [6:0]  seg0;
    logic [3:0]  an0;
    logic        frame0;
    logic [5:0]  value1 = '0;
    logic        load1 = 1'b0;
    logic        blank1 = 1'b0;
    logic [6:0]  seg1;
    logic [1:0]  an1;
    logic        frame1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seg7_scan #(.NUM_DIGITS(4), .DIGIT_BITS(4), .SCAN_DIV(4)) u_hex (
        .clk_i(clk), .rst_i(rst), .value_i(value0), .load_i(load0),
        .blank_i(blank0), .seg_o(seg0), .an_o(an0), .frame_o(frame0)
    );

    seg7_scan #(.NUM_DIGITS(2), .DIGIT_BITS(3), .SCAN_DIV(4)) u_oct (
        .clk_i(clk), .rst_i(rst), .value_i(value1), .load_i(load1),
        .blank_i(blank1), .seg_o(seg1), .an_o(an1), .frame_o(frame1)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] d);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[d];
    endfunction

    function automatic bit ref_suppressed(input logic [15:0] v, input int k);
`ifdef SEG7_LZS_EN
        return (k > 0) && ((v >> (4 * k)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of the hex instance; expected {seg,an,frame} pushed
    // on every edge from the pre-edge model state.
    logic [11:0] exp_q[$];
    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_shd = '0;
    logic [15:0] m_dsp = '0;
    bit          m_pend = 1'b0;
    bit          m_started = 1'b0;

    always @(posedge clk) begin : model
        logic [6:0] es;
        logic [3:0] ea;
        logic       ef;
        if (rst) begin
            es = 7'b1111111; ea = 4'hf; ef = 1'b0;
            m_cnt = 0; m_idx = 0; m_shd = '0; m_dsp = '0;
            m_pend = 1'b0; m_started = 1'b0;
        end else begin
            es = ref_glyph(4'(m_dsp >> (4 * m_idx)));
            ea = 4'hf;
            if (m_cnt != 0 && !blank0 && !ref_suppressed(m_dsp, m_idx)) ea[m_idx] = 1'b0;
            ef = (m_cnt == 0 && m_idx == 0 && m_started);
            if (m_cnt == 3 && m_idx == 3) begin
                if (m_pend) begin
                    m_dsp  = m_shd;
                    m_pend = 1'b0;
                end
                m_started = 1'b1;
            end
            if (load0) begin
                m_shd  = value0;
                m_pend = 1'b1;
            end
            m_cnt = (m_cnt + 1) % 4;
            if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
        end
        exp_q.push_back({es, ea, ef});
    end

    task automatic test_reset();
        logic [11:0] exp;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_reset got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            total++;
            if (seg0 !== 7'b1111111 || an0 !== 4'hf || frame0 !== 1'b0) begin
                bad++; $display("FAIL reset_out got=%b/%b/%b exp=1111111/1111/0", seg0, an0, frame0);
            end
            total++;
            if (an1 !== 2'b11 || frame1 !== 1'b0) begin
                bad++; $display("FAIL reset_oct got=%b/%b exp=11/0", an1, frame1);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_release got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            total++;
            if (an0 !== ((i == 0) ? 4'b1111 : 4'b1110)) begin
                bad++; $display("FAIL release_an%0d got=%b exp=%b", i, an0, (i == 0) ? 4'b1111 : 4'b1110);
            end
        end
    endtask

    task automatic test_hex_scan();
        logic [11:0] exp;
        logic [6:0]  want [4];
        int          frames = 0;
        int          gaps = 0;
        int          k_lit;
        want = '{7'b0001110, 7'b1111000, 7'b0001000, 7'b0110000};
        value0 = 16'h3A7F; load0 = 1'b1;
        @(posedge clk); #1;
        load0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_hex got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            if (i >= 32) begin
                if (frame0) frames++;
                if (an0 == 4'hf) gaps++;
                else begin
                    k_lit = 0;
                    for (int k = 0; k < 4; k++) if (an0[k] == 1'b0) k_lit = k;
                    total++;
                    if (seg0 !== want[k_lit]) begin
                        bad++; $display("FAIL hex_seg digit%0d got=%b exp=%b", k_lit, seg0, want[k_lit]);
                    end
                end
            end
        end
        total++;
        if (frames != 2) begin
            bad++; $display("FAIL hex_frames got=%0d exp=2", frames);
        end
        total++;
        if (gaps != 8) begin
            bad++; $display("FAIL hex_gaps got=%0d exp=8", gaps);
        end
    endtask

    task automatic test_collision();
        logic [11:0] exp;
        int          n = 0;
        value0 = 16'h1111; load0 = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        load0 = 1'b0;
        while (!(m_cnt == 3 && m_idx == 3) && n < 20) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_coll_wait got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++; $display("FAIL coll_wrap_wait got=timeout exp=wrap within 20 cycles");
        end
        value0 = 16'h2222; load0 = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        load0 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_coll got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            if (an0 != 4'hf) begin
                total++;
                if (seg0 !== ((i < 16) ? 7'b1111001 : 7'b0100100)) begin
                    bad++; $display("FAIL coll_seg cyc%0d got=%b exp=%b", i, seg0,
                                    (i < 16) ? 7'b1111001 : 7'b0100100);
                end
            end
        end
    endtask

    task automatic test_octal();
        int lit0 = 0;
        int lit1 = 0;
        for (int pass = 0; pass < 2; pass++) begin
            value1 = (pass == 0) ? 6'o57 : 6'o60; load1 = 1'b1;
            @(posedge clk); #1;
            load1 = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                if (an1 == 2'b10) begin
                    lit0++; total++;
                    if (seg1 !== ((pass == 0) ? 7'b1111000 : 7'b1000000)) begin
                        bad++; $display("FAIL oct_d0 pass%0d got=%b", pass, seg1);
                    end
                end else if (an1 == 2'b01) begin
                    lit1++; total++;
                    if (seg1 !== ((pass == 0) ? 7'b0010010 : 7'b0000010)) begin
                        bad++; $display("FAIL oct_d1 pass%0d got=%b", pass, seg1);
                    end
                end else begin
                    total++;
                    if (an1 !== 2'b11) begin
                        bad++; $display("FAIL oct_an got=%b exp=one-hot-low or 11", an1);
                    end
                end
            end
        end
        total++;
        if (lit0 != 12 || lit1 != 12) begin
            bad++; $display("FAIL oct_lit got=%0d/%0d exp=12/12", lit0, lit1);
        end
        exp_q.delete();
    endtask

    task automatic test_blank_reset();
        logic [11:0] exp;
        int          lit = 0;
        blank0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_blank got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            total++;
            if (an0 !== 4'hf || seg0 !== 7'b0100100) begin
                bad++; $display("FAIL blank_out got=%b/%b exp=0100100/1111", seg0, an0);
            end
        end
        blank0 = 1'b0;
        value0 = 16'h5555; load0 = 1'b1;
        @(posedge clk); #1;
        load0 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            exp = exp_q[$]; exp_q.delete(); total++;
            if ({seg0, an0, frame0} !== exp) begin
                bad++; $display("FAIL sb_rst_mid got=%h exp=%h", {seg0, an0, frame0}, exp);
            end
            if (an0 != 4'hf) begin
                lit++; total++;
                if (seg0 !== 7'b1000000) begin
                    bad++; $display("FAIL rst_mid_seg got=%b exp=1000000", seg0);
                end
            end
        end
        total++;
        if (lit == 0) begin
            bad++; $display("FAIL rst_mid_lit got=0 exp=nonzero");
        end
    endtask

    task automatic test_lzs();
        logic [11:0] exp;
        int          lit_cnt [4];
        for (int pass = 0; pass < 2; pass++) begin
            lit_cnt = '{0, 0, 0, 0};
            value0 = (pass == 0) ? 16'h0050 : 16'h0000; load0 = 1'b1;
            @(posedge clk); #1;
            load0 = 1'b0;
            for (int i = 0; i < 52; i++) begin
                @(posedge clk); #1;
                exp = exp_q[$]; exp_q.delete(); total++;
                if ({seg0, an0, frame0} !== exp) begin
                    bad++; $display("FAIL sb_lzs%0d got=%h exp=%h", pass, {seg0, an0, frame0}, exp);
                end
                if (i >= 20) begin
                    for (int k = 0; k < 4; k++) begin
                        if (an0[k] == 1'b0) begin
                            lit_cnt[k]++; total++;
                            if (seg0 !== ((pass == 0 && k == 1) ? 7'b0010010 : 7'b1000000)) begin
                                bad++; $display("FAIL lzs_seg pass%0d digit%0d got=%b", pass, k, seg0);
                            end
                        end
                    end
                end
            end
            // 32 checked cycles = two scans; a shown digit is lit 3 cycles per scan.
            for (int k = 0; k < 4; k++) begin
                int want;
`ifdef SEG7_LZS_EN
                want = ((pass == 0) ? (k <= 1) : (k == 0)) ? 6 : 0;
`else
                want = 6;
`endif
                total++;
                if (lit_cnt[k] != want) begin
                    bad++; $display("FAIL lzs_lit pass%0d digit%0d got=%0d exp=%0d", pass, k, lit_cnt[k], want);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hex_scan();
        test_collision();
        test_octal();
        test_blank_reset();
        test_lzs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
